finn_feeder_chiplet_mul_arb: RTL and testbench
==============================================

FINN_FEEDER_CHIPLET_MUL_ARB -- requirements
Module: finn_feeder_chiplet_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter din0_WIDTH, default 32: operand A width, unsigned.
REQ-003 SHALL have parameter din1_WIDTH, default 34: operand B width, unsigned.
REQ-004 SHALL have parameter dout_WIDTH, default 65: product width.
REQ-005 SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ bits: per-requester operand-valid flags.
REQ-008 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept strobes, one-hot or zero.
REQ-009 SHALL have port req_a, input, NUM_REQ*din0_WIDTH bits: operand A; requester i occupies slice [i*din0_WIDTH +: din0_WIDTH].
REQ-010 SHALL have port req_b, input, NUM_REQ*din1_WIDTH bits: operand B, sliced the same way as req_a.
REQ-011 SHALL have port out_valid, input/output direction output, 1 bit: result valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port out_prod, output, dout_WIDTH bits: the product.
REQ-014 SHALL have port out_id, output, clog2(NUM_REQ) bits: index of the requester that owns the result.
REQ-015 SHALL have port stat_grants, output, 32 bits: count of accepted requests (see Configuration).

Function
REQ-016 SHALL share one unsigned din0 x din1 multiplier across all requesters.
- Structure: a two-register pipeline. Stage S1 holds the operands and the id. Stage S2 holds the product and the id, and drives out_*.
REQ-017 SHALL compute the product as the zero-extended full product truncated to its low dout_WIDTH bits.
REQ-018 SHALL advance the pipeline as follows:
- S2 advances when out_valid is 0 or out_ready is 1.
- S1 is free when S1 is empty or S1 moves into S2 in the same cycle.
REQ-019 SHALL assert a grant only when S1 is free. At most one req_ready bit is high, and only for a requester whose req_valid is high.
- A transfer is req_valid[i] && req_ready[i], sampled on the clock edge.
REQ-020 SHALL make req_ready combinational from req_valid, the round-robin pointer and the pipeline state. It SHALL have no dependency on req_a or req_b.
REQ-021 SHALL use a round-robin pointer with reset value 0.
- Search starts at the pointer index and goes upward modulo NUM_REQ.
- After a transfer from requester i, the pointer becomes (i+1) mod NUM_REQ.
- With no transfer, the pointer holds.
REQ-022 SHALL assert out_valid with the matching out_prod and out_id on the second rising edge after the transfer edge, assuming out_ready stays high.
- Sustained throughput is one result per cycle.
REQ-023 SHALL hold out_prod and out_id stable while out_valid=1 and out_ready=0.
- Backpressure SHALL propagate: S1 fills, then all req_ready go low. No data is lost or duplicated.
REQ-024 SHALL move S2 out and S1 into S2 in the same cycle when both happen, and SHALL accept a new grant into S1 in that same cycle.
REQ-025 SHALL deliver results in grant order.
- Wrap-around: after a grant to requester NUM_REQ-1, the pointer returns to 0.

Reset
REQ-026 SHALL apply all of the following immediately while ap_rst=1, independent of ap_clk:
- out_valid=0, the S1 valid flag cleared, the pointer set to 0, stat_grants=0.
- out_prod=0 and out_id=0.
- req_ready=0.
REQ-027 SHALL discard any operation in flight when reset asserts mid-operation. The first grant after release goes to the lowest-index valid requester.

Configuration
REQ-028 SHALL use the macro FINN_MUL_ARB_STATS_EN.
- When defined: stat_grants increments by 1 on every transfer and wraps from 0xFFFFFFFF to 0.
- When undefined: stat_grants is the constant 0 and no counter logic is generated.

Verification
REQ-029 SHALL cover these directed scenarios:
- Single request: req_valid=4'b0001, a=3, b=5, out_ready=1 -> req_ready=4'b0001 in cycle 0; out_valid=1, out_prod=15, out_id=0 after the second edge.
- All four valid continuously, out_ready=1 -> grants go 0,1,2,3,0,... once per cycle; out_id matches that order.
- Max operands: a=0xFFFFFFFF, b=0x3_FFFFFFFF -> out_prod equals the low 65 bits of the 66-bit product, 0x1_FFFFFFFB_00000001.
- out_ready=0 for 5 cycles with requester 2 streaming -> out_* holds; req_ready drops after 2 accepts; on release, results arrive in order with none missing.
- ap_rst pulsed mid-stream, asynchronously between edges -> out_valid=0 immediately, stat_grants=0 (STATS on), next grant goes to the lowest valid index.
- Build without FINN_MUL_ARB_STATS_EN -> stat_grants=0 throughout the all-valid scenario.

Source files
------------

// File: rtl/finn_feeder_chiplet_mul_arb.sv
// rtl/finn_feeder_chiplet_mul_arb.sv - round-robin arbiter feeding one shared two-stage multiplier pipeline
// Optional grant counter on stat_grants is enabled by defining FINN_MUL_ARB_STATS_EN.
module finn_feeder_chiplet_mul_arb #(
  parameter int NUM_REQ    = 4,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 34,
  parameter int dout_WIDTH = 65
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*din0_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*din1_WIDTH-1:0]  req_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [dout_WIDTH-1:0]          out_prod,
  output logic [$clog2(NUM_REQ)-1:0]     out_id,
  output logic [31:0]                    stat_grants
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int FPW = din0_WIDTH + din1_WIDTH;
  localparam int MW  = (FPW > dout_WIDTH) ? FPW : dout_WIDTH;

  logic [IDW-1:0]        ptr;
  logic                  s1_valid;
  logic [din0_WIDTH-1:0] s1_a;
  logic [din1_WIDTH-1:0] s1_b;
  logic [IDW-1:0]        s1_id;

  logic                  s2_adv;
  logic                  s1_free;
  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic [IDW:0]          search_sum;
  logic [IDW-1:0]        search_idx;
  logic                  xfer;
  logic [dout_WIDTH-1:0] prod;

  assign s2_adv  = !out_valid || out_ready;
  assign s1_free = !s1_valid || s2_adv;

  // Round-robin search: first valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_sum  = '0;
    search_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (search_sum >= (IDW+1)'(NUM_REQ)) begin
        search_sum = search_sum - (IDW+1)'(NUM_REQ);
      end
      search_idx = search_sum[IDW-1:0];
      if (!grant_found && req_valid[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  // Grant only when S1 can take data; forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (!ap_rst && s1_free && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  assign xfer = !ap_rst && s1_free && grant_found;

  // Zero-extended full product, truncated to the output width.
  assign prod = dout_WIDTH'(MW'(s1_a) * MW'(s1_b));

  // Round-robin pointer: moves past the granted requester on each transfer.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Stage S1: captures the granted requester's operands and id.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (s1_free) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a  <= req_a[grant_idx*din0_WIDTH +: din0_WIDTH];
        s1_b  <= req_b[grant_idx*din1_WIDTH +: din1_WIDTH];
        s1_id <= grant_idx;
      end
    end
  end

  // Stage S2: registers the product; holds while downstream stalls.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_prod <= prod;
        out_id   <= s1_id;
      end
    end
  end

`ifdef FINN_MUL_ARB_STATS_EN
  logic [31:0] grant_cnt;

  // Transfer counter, wraps naturally at 32 bits.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      grant_cnt <= '0;
    end else if (xfer) begin
      grant_cnt <= grant_cnt + 32'd1;
    end
  end

  assign stat_grants = grant_cnt;
`else
  assign stat_grants = 32'd0;
`endif

endmodule

// File: tb/tb_finn_feeder_chiplet_mul_arb.sv
// tb/tb_finn_feeder_chiplet_mul_arb.sv - scoreboard bench for the arbitrated shared multiplier
module tb_finn_feeder_chiplet_mul_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 34;
  localparam int PW = 65;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_prod;
  logic [1:0]      out_id;
  logic [31:0]     stat_grants;

  finn_feeder_chiplet_mul_arb dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_prod    (out_prod),
    .out_id      (out_id),
    .stat_grants (stat_grants)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [1:0]    id;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic          m_s1 = 1'b0;
  logic          m_s2 = 1'b0;
  int            m_ptr = 0;
  logic [31:0]   m_stats = '0;
  logic          ovr_en = 1'b0;
  logic [PW-1:0] ovr_prod = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stats();
`ifdef FINN_MUL_ARB_STATS_EN
    return m_stats;
`else
    return 32'd0;
`endif
  endfunction

  // One clock cycle: check outputs against the model at negedge, predict the transfer, advance the model.
  task automatic step();
    logic s2_adv, s1_free, found;
    int g;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [65:0]   full;
    exp_t e;
    @(negedge ap_clk);
    s2_adv  = !m_s2 || out_ready;
    s1_free = !m_s1 || s2_adv;
    found = 1'b0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    exp_ready = (s1_free && found) ? (N'(1) << g) : '0;
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    chk("out_valid", 128'(out_valid), 128'(m_s2));
    chk("stat_grants", 128'(stat_grants), 128'(exp_stats()));
    if (s1_free && found) begin
      a = req_a[g*AW +: AW];
      b = req_b[g*BW +: BW];
      full = {34'b0, a} * {32'b0, b};
      e.id = 2'(g);
      e.prod = ovr_en ? ovr_prod : full[PW-1:0];
      sbq.push_back(e);
    end
    @(posedge ap_clk);
    if (s2_adv) m_s2 = m_s1;
    if (s1_free) m_s1 = found;
    if (s1_free && found) begin
      m_ptr = (g + 1) % N;
      m_stats = m_stats + 32'd1;
    end
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (m_s1 || m_s2); i++) step();
    chk("drain_empty", 128'(sbq.size()), 128'(0));
  endtask

  // Monitor: compares every presented result with the scoreboard head; pops on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst && out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got id %0d prod %0h with empty scoreboard", out_id, out_prod);
        end else begin
          e = sbq[0];
          if (out_prod !== e.prod || out_id !== e.id) begin
            errors++;
            $display("FAIL result: got id %0d prod %0h expected id %0d prod %0h", out_id, out_prod, e.id, e.prod);
          end
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;

    // Asynchronous reset before any clock edge
    #1 ap_rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_prod", 128'(out_prod), 128'(0));
    chk("rst_out_id", 128'(out_id), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_stat", 128'(stat_grants), 128'(0));
    @(posedge ap_clk);
    @(posedge ap_clk);
    #3 ap_rst = 1'b0;

    // Single request: 3 x 5 = 15 from requester 0
    req_valid = 4'b0001;
    req_a[0*AW +: AW] = 32'd3;
    req_b[0*BW +: BW] = 34'd5;
    step();
    req_valid = '0;
    step();
    chk("single_prod", 128'(out_prod), 128'(15));
    chk("single_id", 128'(out_id), 128'(0));
    drain();

    // All four valid: grants rotate once per cycle
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*AW +: AW] = 32'(100 * c + i + 1);
        req_b[i*BW +: BW] = 34'(7 * c + 3 * i + 2);
      end
      step();
    end
    drain();

    // Maximum operands on requester 2
    req_a[2*AW +: AW] = 32'hFFFF_FFFF;
    req_b[2*BW +: BW] = 34'h3_FFFF_FFFF;
    req_valid = 4'b0100;
    ovr_en = 1'b1;
    ovr_prod = 65'h1_FFFF_FFFB_0000_0001;
    step();
    ovr_en = 1'b0;
    req_valid = '0;
    drain();

    // Backpressure: requester 2 streams while downstream stalls for 5 cycles
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      req_a[2*AW +: AW] = 32'(c + 2);
      req_b[2*BW +: BW] = 34'(c + 7);
      step();
    end
    chk("stall_queue_depth", 128'(sbq.size()), 128'(2));
    out_ready = 1'b1;
    for (int c = 5; c < 9; c++) begin
      req_a[2*AW +: AW] = 32'(c + 2);
      req_b[2*BW +: BW] = 34'(c + 7);
      step();
    end
    drain();

    // Reset pulsed mid-stream between clock edges
    req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*AW +: AW] = 32'(c + i + 9);
        req_b[i*BW +: BW] = 34'(2 * c + i + 1);
      end
      step();
    end
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_stat", 128'(stat_grants), 128'(0));
    chk("midrst_req_ready", 128'(req_ready), 128'(0));
    sbq.delete();
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    m_ptr = 0;
    m_stats = '0;
    @(posedge ap_clk);
    #3 ap_rst = 1'b0;
    req_valid = 4'b1010;
    req_a[1*AW +: AW] = 32'd6;
    req_b[1*BW +: BW] = 34'd7;
    step();
    req_valid = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
